// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath blocks: FP16 width, default
// arithmetic latencies and the MAC sequencer state encoding.
package nn_pkg;

  localparam int FP16_W      = 16;
  localparam int MUL_LAT_DEF = 1;
  localparam int ADD_LAT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RD,
    ST_MUL,
    ST_ADD,
    ST_ACC,
    ST_FIN
  } mac_state_t;

endpackage

// File: rtl/neuron_mac_ctrl_lat_counter.sv
// Load/decrement wait counter; zero is high once the loaded count has run out.
module lat_counter
  import nn_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/neuron_mac_ctrl.sv
// Sequencer for one neuron's serial FP16 multiply-accumulate: read, multiply,
// add, then load the running sum, one element at a time.
module neuron_mac_ctrl
  import nn_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mul_en,
  output logic              add_en,
  output logic              sum_rst,
  output logic              sum_en,
  output logic              busy,
  output logic              done
);

  localparam int LAT_MAX = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] ADD_LOAD = CNT_W'(ADD_LAT - 1);

  mac_state_t        state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_nxt;
  logic              cnt_load;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt_val;

  // One counter serves both waits: loaded entering MUL, reloaded entering ADD.
  always_comb begin
    cnt_load = (state == ST_RD) || ((state == ST_MUL) && cnt_zero);
    cnt_val  = (state == ST_RD) ? MUL_LOAD : ADD_LOAD;
    idx_nxt  = idx + 1'b1;
  end

  lat_counter #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Strobes are registered together with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      idx       <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      mul_en    <= 1'b0;
      add_en    <= 1'b0;
      sum_rst   <= 1'b0;
      sum_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      mul_en    <= 1'b0;
      add_en    <= 1'b0;
      sum_rst   <= 1'b0;
      sum_en    <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: if (start) begin
            len_q   <= len;
            idx     <= '0;
            state   <= ST_CLR;
            sum_rst <= 1'b1;
            busy    <= 1'b1;
          end
          ST_CLR: if (len_q == '0) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else begin
            state     <= ST_RD;
            mem_rd_en <= 1'b1;
            mem_addr  <= idx[ADDR_W-1:0];
          end
          ST_RD: begin
            state  <= ST_MUL;
            mul_en <= 1'b1;
          end
          ST_MUL: if (cnt_zero) begin
            state  <= ST_ADD;
            add_en <= 1'b1;
          end
          ST_ADD: if (cnt_zero) begin
            state  <= ST_ACC;
            sum_en <= 1'b1;
          end
          ST_ACC: if (idx == len_q - 1'b1) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else begin
            idx       <= idx_nxt;
            state     <= ST_RD;
            mem_rd_en <= 1'b1;
            mem_addr  <= idx_nxt[ADDR_W-1:0];
          end
          ST_FIN: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Scoreboard bench: three sequencer configurations driven in parallel, expected
// strobe events queued from a cycle-timing model and checked by one monitor.
module tb_neuron_mac_ctrl;
  import nn_pkg::*;

  localparam int N = 3;

  // flags: [5]=mem_rd_en [4]=mul_en [3]=add_en [2]=sum_rst [1]=sum_en [0]=done
  typedef struct {
    int          cyc;
    logic [5:0]  flags;
    int          addr;
    logic [15:0] sum;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_w [N];
  logic       abort_w [N];
  logic [6:0] len_w   [N];
  logic       rd_w    [N];
  logic       mul_w   [N];
  logic       add_w   [N];
  logic       srst_w  [N];
  logic       sen_w   [N];
  logic       busy_w  [N];
  logic       done_w  [N];
  logic [5:0] addr_w  [N];

  ev_t exp_q [N][$];
  int  busy_from [N];
  int  busy_to   [N];
  int  sum_cnt   [N];
  int  cyc = 0;
  int  errs = 0;
  int  checks = 0;
  bit  final_req = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int aw_of(int g); return (g == 2) ? 2 : 6; endfunction
  function automatic int ml_of(int g); return (g == 1) ? 3 : 1; endfunction
  function automatic int al_of(int g); return (g == 1) ? 2 : 1; endfunction

  // Sum register contents as FP16 when it holds the small integer n.
  function automatic logic [15:0] fp16_of(int n);
    int e;
    logic [15:0] r;
    if (n <= 0) return 16'h0000;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    r[15]    = 1'b0;
    r[14:10] = 5'(e + 15);
    r[9:0]   = 10'((n << 10) >> e);
    return r;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int AW = (g == 2) ? 2 : 6;
    localparam int ML = (g == 1) ? 3 : 1;
    localparam int AL = (g == 1) ? 2 : 1;
    logic [AW-1:0] a;
    neuron_mac_ctrl #(.ADDR_W(AW), .MUL_LAT(ML), .ADD_LAT(AL)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_w[g]),
      .len       (len_w[g][AW:0]),
      .abort     (abort_w[g]),
      .mem_rd_en (rd_w[g]),
      .mem_addr  (a),
      .mul_en    (mul_w[g]),
      .add_en    (add_w[g]),
      .sum_rst   (srst_w[g]),
      .sum_en    (sen_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g])
    );
    assign addr_w[g] = 6'(a);
  end

  function automatic ev_t mk(int c, logic [5:0] f, int a, logic [15:0] s);
    ev_t e;
    e.cyc = c; e.flags = f; e.addr = a; e.sum = s;
    return e;
  endfunction

  // Start issued at the negedge where cyc==c0; spec cycle k+o is seen at cyc c0+o.
  task automatic push_run(input int g, input int c0, input int l);
    int per, b;
    per = 2 + ml_of(g) + al_of(g);
    exp_q[g].push_back(mk(c0 + 1, 6'b000100, 0, 16'h0));
    for (int i = 0; i < l; i++) begin
      b = c0 + 2 + i * per;
      exp_q[g].push_back(mk(b, 6'b100000, i, 16'h0));
      exp_q[g].push_back(mk(b + 1, 6'b010000, 0, 16'h0));
      exp_q[g].push_back(mk(b + 1 + ml_of(g), 6'b001000, 0, 16'h0));
      exp_q[g].push_back(mk(b + 1 + ml_of(g) + al_of(g), 6'b000010, 0, 16'h0));
    end
    exp_q[g].push_back(mk(c0 + 2 + l * per, 6'b000001, 0, fp16_of(l)));
    busy_from[g] = c0 + 1;
    busy_to[g]   = c0 + 2 + l * per;
  endtask

  // Abort sampled at the edge after cycle c1: nothing later than c1 happens.
  task automatic cut_run(input int g, input int c1);
    while (exp_q[g].size() > 0 && exp_q[g][exp_q[g].size() - 1].cyc > c1)
      void'(exp_q[g].pop_back());
    if (busy_to[g] > c1) busy_to[g] = c1;
  endtask

  initial begin
    int c0, lim, maxd, per, doff;
    int ln [N];
    int ab [N];
    for (int g = 0; g < N; g++) begin
      start_w[g] = 1'b0; abort_w[g] = 1'b0; len_w[g] = '0;
      busy_from[g] = 0; busy_to[g] = -1; sum_cnt[g] = 0;
    end
    // start during reset must be ignored
    @(negedge clk);
    for (int g = 0; g < N; g++) begin start_w[g] = 1'b1; len_w[g] = 7'd3; end
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < N; g++) start_w[g] = 1'b0;
    repeat (2) @(negedge clk);

    // basic len=4, latency-config len=2, full-length len=4 on ADDR_W=2
    c0 = cyc;
    len_w[0] = 7'd4; len_w[1] = 7'd2; len_w[2] = 7'd4;
    for (int g = 0; g < N; g++) begin
      start_w[g] = 1'b1;
      push_run(g, c0, int'(len_w[g]));
    end
    @(negedge clk);
    for (int g = 0; g < N; g++) start_w[g] = 1'b0;
    repeat (4) @(negedge clk);
    // start while busy has no effect
    start_w[0] = 1'b1; start_w[2] = 1'b1; len_w[0] = 7'd1; len_w[2] = 7'd1;
    @(negedge clk);
    start_w[0] = 1'b0; start_w[2] = 1'b0;
    repeat (40) @(negedge clk);

    // zero length
    c0 = cyc;
    for (int g = 0; g < 2; g++) begin
      len_w[g] = 7'd0; start_w[g] = 1'b1; push_run(g, c0, 0);
    end
    @(negedge clk);
    start_w[0] = 1'b0; start_w[1] = 1'b0;
    repeat (6) @(negedge clk);

    // abort in the MUL cycle of element 1, then restart from address 0
    c0 = cyc;
    len_w[0] = 7'd4; start_w[0] = 1'b1; push_run(0, c0, 4);
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (6) @(negedge clk);
    abort_w[0] = 1'b1; cut_run(0, cyc);
    @(negedge clk);
    abort_w[0] = 1'b0;
    repeat (4) @(negedge clk);
    c0 = cyc;
    len_w[0] = 7'd2; start_w[0] = 1'b1; push_run(0, c0, 2);
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (15) @(negedge clk);

    // start and abort together in IDLE: stays idle
    start_w[1] = 1'b1; abort_w[1] = 1'b1; len_w[1] = 7'd3;
    @(negedge clk);
    start_w[1] = 1'b0; abort_w[1] = 1'b0;
    repeat (4) @(negedge clk);

    // randomized runs with occasional aborts
    for (int it = 0; it < 8; it++) begin
      c0 = cyc; maxd = 0;
      for (int g = 0; g < N; g++) begin
        lim = 1 << aw_of(g);
        if (lim > 10) lim = 10;
        ln[g] = $urandom_range(0, lim);
        per = 2 + ml_of(g) + al_of(g);
        doff = 2 + ln[g] * per;
        if (doff > maxd) maxd = doff;
        ab[g] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, doff - 1)) : -1;
        len_w[g] = 7'(ln[g]); start_w[g] = 1'b1;
        push_run(g, c0, ln[g]);
      end
      @(negedge clk);
      for (int g = 0; g < N; g++) start_w[g] = 1'b0;
      for (int t = 1; t <= maxd + 3; t++) begin
        for (int g = 0; g < N; g++) begin
          abort_w[g] = (ab[g] == t);
          if (ab[g] == t) cut_run(g, cyc);
        end
        @(negedge clk);
      end
      for (int g = 0; g < N; g++) abort_w[g] = 1'b0;
    end
    final_req = 1'b1;
  end

  always @(negedge clk) begin
    logic [5:0] f;
    bit         eb;
    ev_t        e;
    if (final_req || cyc > 4000) begin
      if (!final_req) begin
        errs++;
        $display("FAIL timeout: cycle %0d reached, required end before 4000", cyc);
      end
      for (int g = 0; g < N; g++) begin
        checks++;
        if (exp_q[g].size() != 0) begin
          errs++;
          $display("FAIL pending_%0d: %0d expected events never seen, next at cycle %0d flags %b",
                   g, exp_q[g].size(), exp_q[g][0].cyc, exp_q[g][0].flags);
        end
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
    end
    for (int g = 0; g < N; g++) begin
      f  = {rd_w[g], mul_w[g], add_w[g], srst_w[g], sen_w[g], done_w[g]};
      eb = (cyc >= busy_from[g]) && (cyc <= busy_to[g]);
      checks++;
      if (busy_w[g] !== eb) begin
        errs++;
        $display("FAIL busy_%0d: cycle %0d got %b, required %b", g, cyc, busy_w[g], eb);
      end
      if (rst) begin
        checks++;
        if (addr_w[g] !== 6'd0) begin
          errs++;
          $display("FAIL rst_addr_%0d: got %0d, required 0", g, addr_w[g]);
        end
      end
      if (f[2]) sum_cnt[g] = 0;
      if (f[1]) sum_cnt[g]++;
      if (f != 6'b0) begin
        checks++;
        if (exp_q[g].size() == 0) begin
          errs++;
          $display("FAIL extra_%0d: cycle %0d got strobes %b, required none", g, cyc, f);
        end else begin
          e = exp_q[g].pop_front();
          if (e.cyc != cyc || e.flags !== f || (f[5] && int'(addr_w[g]) != e.addr)) begin
            errs++;
            $display("FAIL event_%0d: got cycle %0d strobes %b addr %0d, required cycle %0d strobes %b addr %0d",
                     g, cyc, f, addr_w[g], e.cyc, e.flags, e.addr);
          end
          if (f[0] && e.flags[0]) begin
            checks++;
            if (fp16_of(sum_cnt[g]) !== e.sum) begin
              errs++;
              $display("FAIL sum_%0d: got %h, required %h", g, fp16_of(sum_cnt[g]), e.sum);
            end
          end
        end
      end
    end
  end

endmodule
